conv_layer_stream: RTL and testbench

- Sequential, parametrised successor to the combinational single-layer convolution block.
- Accepts one unpadded-or-prepadded image as a raster pixel stream with valid/ready.
- Holds KSIZE-1 image rows in line buffers and a KSIZE x KSIZE sliding window.
- Produces NUM_CH valid-mode feature-map pixels per window position, with shift, saturation and output backpressure; sits between the image DMA/pad stage and the pooling stage.

---
 rtl/conv_layer_stream.sv | 180 ++++++++++++++++++
 tb/tb_conv_layer_stream.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streaming KSIZE x KSIZE valid-mode convolution producing NUM_CH
// feature-map channels per window position, with shift, saturation and backpressure.
// Optional ReLU on every channel result: define CONV_LAYER_STREAM_RELU_EN.
module conv_layer_stream #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned IMG_W    = 32,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned KSIZE    = 5,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SHIFT    = 4
) (
  input  logic                                                            clk,
  input  logic                                                            rst_n,
  input  logic                                                            kernel_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]                  kernel_ch,
  input  logic [$clog2(KSIZE)-1:0]                                        kernel_row,
  input  logic [$clog2(KSIZE)-1:0]                                        kernel_col,
  input  logic [BITWIDTH-1:0]                                             kernel_data,
  input  logic                                                            start,
  output logic                                                            busy,
  input  logic                                                            pix_valid,
  output logic                                                            pix_ready,
  input  logic [BITWIDTH-1:0]                                             pix_data,
  output logic                                                            fm_valid,
  input  logic                                                            fm_ready,
  output logic [NUM_CH*BITWIDTH-1:0]                                      fm_data,
  output logic [(((IMG_H-KSIZE+1) > 1) ? $clog2(IMG_H-KSIZE+1) : 1)-1:0]  fm_row,
  output logic [(((IMG_W-KSIZE+1) > 1) ? $clog2(IMG_W-KSIZE+1) : 1)-1:0]  fm_col,
  output logic                                                            frame_done
);

  localparam int unsigned OUT_W = IMG_W - KSIZE + 1;
  localparam int unsigned OUT_H = IMG_H - KSIZE + 1;
  localparam int unsigned ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ACC_W = 2 * BITWIDTH + $clog2(KSIZE * KSIZE);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BITWIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_frame_done;
  logic                        r_fm_valid;
  logic [NUM_CH*BITWIDTH-1:0]  r_fm_data;
  logic [ORW-1:0]              r_fm_row;
  logic [OCW-1:0]              r_fm_col;
  logic [RW-1:0]               r_row;
  logic [CW-1:0]               r_col;
  logic signed [BITWIDTH-1:0]  r_kern [NUM_CH][KSIZE][KSIZE];
  logic signed [BITWIDTH-1:0]  r_lb   [KSIZE-1][IMG_W];
  logic signed [BITWIDTH-1:0]  r_win  [KSIZE][KSIZE];

  logic signed [BITWIDTH-1:0]  w_col  [KSIZE];
  logic signed [BITWIDTH-1:0]  w_nwin [KSIZE][KSIZE];
  logic signed [ACC_W-1:0]     w_sum  [NUM_CH];
  logic signed [ACC_W-1:0]     w_shf  [NUM_CH];
  logic signed [BITWIDTH-1:0]  w_res  [NUM_CH];
  logic                        w_pix_ready;
  logic                        w_pix_acc;
  logic                        w_last_pix;
  logic                        w_emit;
  logic                        w_kern_ok;

  assign w_pix_ready = (r_state == S_STREAM) && (!r_fm_valid || fm_ready);
  assign w_pix_acc   = pix_valid && w_pix_ready;
  assign w_last_pix  = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
  assign w_emit      = w_pix_acc && (r_row >= RW'(KSIZE - 1)) && (r_col >= CW'(KSIZE - 1));
  assign w_kern_ok   = (32'(kernel_ch) < NUM_CH) && (32'(kernel_row) < KSIZE) &&
                       (32'(kernel_col) < KSIZE);

  assign busy       = r_busy;
  assign pix_ready  = w_pix_ready;
  assign fm_valid   = r_fm_valid;
  assign fm_data    = r_fm_data;
  assign fm_row     = r_fm_row;
  assign fm_col     = r_fm_col;
  assign frame_done = r_frame_done;

  // Incoming column (line-buffer rows oldest first, then the live pixel) and shifted window.
  always_comb begin
    for (int i = 0; i < KSIZE - 1; i++) w_col[i] = r_lb[i][r_col];
    w_col[KSIZE-1] = pix_data;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE - 1; j++) w_nwin[i][j] = r_win[i][j+1];
      w_nwin[i][KSIZE-1] = w_col[i];
    end
  end

  // Per-channel multiply-accumulate, floor shift, saturation and optional ReLU.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sum[ch] = '0;
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE; j++) begin
          w_sum[ch] = w_sum[ch] + ACC_W'(w_nwin[i][j]) * ACC_W'(r_kern[ch][i][j]);
        end
      end
      w_shf[ch] = w_sum[ch] >>> SHIFT;
      if (w_shf[ch] > SAT_MAX)      w_res[ch] = BITWIDTH'(SAT_MAX);
      else if (w_shf[ch] < SAT_MIN) w_res[ch] = BITWIDTH'(SAT_MIN);
      else                          w_res[ch] = BITWIDTH'(w_shf[ch]);
`ifdef CONV_LAYER_STREAM_RELU_EN
      if (w_res[ch][BITWIDTH-1]) w_res[ch] = '0;
`endif
    end
  end

  // Line buffers shift vertically per column; window shifts left on every accepted pixel.
  always_ff @(posedge clk) begin
    if (w_pix_acc) begin
      for (int k = 0; k < KSIZE - 2; k++) r_lb[k][r_col] <= r_lb[k+1][r_col];
      r_lb[KSIZE-2][r_col] <= pix_data;
      r_win <= w_nwin;
    end
  end

  // Frame FSM, pixel counters, kernel store and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_fm_valid   <= 1'b0;
      r_fm_data    <= '0;
      r_fm_row     <= '0;
      r_fm_col     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      for (int ch = 0; ch < NUM_CH; ch++)
        for (int i = 0; i < KSIZE; i++)
          for (int j = 0; j < KSIZE; j++) r_kern[ch][i][j] <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (kernel_we && w_kern_ok) r_kern[kernel_ch][kernel_row][kernel_col] <= kernel_data;
          if (start) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_STREAM: begin
          if (w_pix_acc) begin
            if (r_col == CW'(IMG_W - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_last_pix) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!r_fm_valid || fm_ready) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_emit) begin
        r_fm_valid <= 1'b1;
        r_fm_row   <= ORW'(r_row - RW'(KSIZE - 1));
        r_fm_col   <= OCW'(r_col - CW'(KSIZE - 1));
        for (int ch = 0; ch < NUM_CH; ch++) r_fm_data[ch*BITWIDTH +: BITWIDTH] <= w_res[ch];
      end else if (fm_ready) begin
        r_fm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// tb_conv_layer_stream: directed bench for conv_layer_stream (default build and a small
// parameter sweep instance). Expected values follow CONV_LAYER_STREAM_RELU_EN when defined.
`timescale 1ns/1ps
module tb_conv_layer_stream;
  localparam int W = 32, H = 32, NCH = 2, OW = 28, OH = 28;
  localparam int NPIX = W * H, NOUT = OW * OH;
  localparam int T_IDENT = 0, T_CORNER = 1, T_BOX = 2, T_SATP = 3, T_SATN = 4, T_ZERO = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        kernel_we, start, busy, pix_valid, pix_ready, fm_valid, fm_ready, frame_done;
  logic [0:0]  kernel_ch;
  logic [2:0]  kernel_row, kernel_col;
  logic [7:0]  kernel_data, pix_data;
  logic [15:0] fm_data;
  logic [4:0]  fm_row, fm_col;

  // sweep instance
  logic        s_kernel_we, s_start, s_busy, s_pix_valid, s_pix_ready, s_fm_valid, s_fm_ready;
  logic        s_frame_done;
  logic [1:0]  s_kernel_ch, s_kernel_row, s_kernel_col;
  logic [11:0] s_kernel_data, s_pix_data;
  logic [35:0] s_fm_data;
  logic [2:0]  s_fm_row, s_fm_col;

  int n_total = 0;
  int n_bad   = 0;
  int n_quiet;
  int s_img [7][10];
  int s_k   [3][3][3];

  conv_layer_stream dut (
    .clk(clk), .rst_n(rst_n), .kernel_we(kernel_we), .kernel_ch(kernel_ch),
    .kernel_row(kernel_row), .kernel_col(kernel_col), .kernel_data(kernel_data),
    .start(start), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .fm_valid(fm_valid), .fm_ready(fm_ready), .fm_data(fm_data),
    .fm_row(fm_row), .fm_col(fm_col), .frame_done(frame_done)
  );

  conv_layer_stream #(
    .BITWIDTH(12), .IMG_W(10), .IMG_H(7), .KSIZE(3), .NUM_CH(3), .SHIFT(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .kernel_we(s_kernel_we), .kernel_ch(s_kernel_ch),
    .kernel_row(s_kernel_row), .kernel_col(s_kernel_col), .kernel_data(s_kernel_data),
    .start(s_start), .busy(s_busy), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .pix_data(s_pix_data), .fm_valid(s_fm_valid), .fm_ready(s_fm_ready), .fm_data(s_fm_data),
    .fm_row(s_fm_row), .fm_col(s_fm_col), .frame_done(s_frame_done)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV_LAYER_STREAM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int pix(input int tid, input int r, input int c);
    case (tid)
      T_CORNER: return (3 * r + c) % 64;
      T_BOX:    return 1;
      T_SATP:   return 127;
      T_SATN:   return -128;
      default:  return (r + c) % 64;
    endcase
  endfunction

  function automatic int tap(input int tid, input int ch, input int i, input int j);
    case (tid)
      T_IDENT:  return (ch == 0 && i == 2 && j == 2) ? 16 : 0;
      T_CORNER: return ((ch == 0 && i == 0 && j == 0) || (ch == 1 && i == 4 && j == 3)) ? 16 : 0;
      T_BOX:    return (ch == 0) ? 16 : -16;
      default:  return (ch == 0) ? 127 : -128;
    endcase
  endfunction

  // hand-derived closed forms per test
  function automatic int expv(input int tid, input int row, input int col, input int ch);
    case (tid)
      T_IDENT:  return (ch == 0) ? (row + col + 4) % 64 : 0;
      T_CORNER: return (ch == 0) ? (3 * row + col) % 64 : (3 * row + col + 15) % 64;
      T_BOX:    return (ch == 0) ? 25 : relu(-25);
      T_SATP:   return (ch == 0) ? 127 : relu(-128);
      T_SATN:   return (ch == 0) ? relu(-128) : 127;
      default:  return 0;
    endcase
  endfunction

  function automatic longint exp_word(input int tid, input int row, input int col);
    logic [7:0] e0, e1;
    e0 = 8'(expv(tid, row, col, 0));
    e1 = 8'(expv(tid, row, col, 1));
    return longint'({5'(row), 5'(col), e1, e0});
  endfunction

  function automatic int s_model(input int r, input int c, input int ch);
    int sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) sum += s_img[r+i][c+j] * s_k[ch][i][j];
    sum = sum >>> 4;
    if (sum > 2047) sum = 2047;
    if (sum < -2048) sum = -2048;
    return relu(sum);
  endfunction

  task automatic load_kernels(input int tid);
    for (int ch = 0; ch < NCH; ch++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          kernel_we   = 1'b1;
          kernel_ch   = 1'(ch);
          kernel_row  = 3'(i);
          kernel_col  = 3'(j);
          kernel_data = 8'(tap(tid, ch, i, j));
        end
    @(negedge clk);
    kernel_we = 1'b0;
  endtask

  // One frame; poke drives kernel_we/start mid-stream, abort_at>=0 pulses rst_n there.
  task automatic run_frame(input string tag, input int tid, input int rdy_pct,
                           input bit poke, input int abort_at);
    int pix_idx = 0, out_idx = 0, n_err = 0, n_bp = 0, n_stab = 0, cyc = 0;
    int last_hs = -100, done_cyc = 0;
    bit stalled = 1'b0, done = 1'b0;
    logic [25:0] held = '0;
    longint got, want;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk({tag, "_busy"}, longint'(busy), 1);
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      fm_ready  = ($urandom_range(0, 99) < rdy_pct);
      pix_valid = (pix_idx < NPIX);
      pix_data  = 8'(pix(tid, pix_idx / W, pix_idx % W));
      kernel_we   = poke && (pix_idx == 100);
      start       = poke && (pix_idx == 100);
      kernel_ch   = 1'b0;
      kernel_row  = 3'd0;
      kernel_col  = 3'd0;
      kernel_data = 8'd48;
      #1;
      if (abort_at >= 0 && pix_idx == abort_at) begin
        chk({tag, "_pre_valid"}, longint'(fm_valid), 1);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, longint'(busy), 0);
        chk({tag, "_rst_fm_valid"}, longint'(fm_valid), 0);
        chk({tag, "_rst_pix_ready"}, longint'(pix_ready), 0);
        chk({tag, "_rst_fm_word"}, longint'({fm_row, fm_col, fm_data}), 0);
        return;
      end
      if (fm_valid && !fm_ready && pix_ready) n_bp++;
      if (stalled && (!fm_valid || {fm_row, fm_col, fm_data} != held)) n_stab++;
      stalled = fm_valid && !fm_ready;
      held    = {fm_row, fm_col, fm_data};
      if (frame_done) begin
        done     = 1'b1;
        done_cyc = cyc;
      end
      if (fm_valid && fm_ready) begin
        got  = longint'({fm_row, fm_col, fm_data});
        want = (out_idx < NOUT) ? exp_word(tid, out_idx / OW, out_idx % OW) : -1;
        if (got != want) n_err++;
        if (out_idx < 2 || out_idx == NOUT - 1 || (got != want && n_err == 1))
          chk({tag, "_out"}, got, want);
        out_idx++;
        last_hs = cyc;
      end
      if (pix_valid && pix_ready) pix_idx++;
    end
    kernel_we = 1'b0;
    start     = 1'b0;
    pix_valid = 1'b0;
    chk({tag, "_frame_done_seen"}, longint'(done), 1);
    chk({tag, "_nout"}, out_idx, NOUT);
    chk({tag, "_nerr"}, n_err, 0);
    chk({tag, "_done_lat"}, done_cyc - last_hs, 1);
    if (rdy_pct < 100) begin
      chk({tag, "_ready_while_stalled"}, n_bp, 0);
      chk({tag, "_stall_unstable"}, n_stab, 0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, longint'(frame_done), 0);
    chk({tag, "_idle_busy"}, longint'(busy), 0);
  endtask

  task automatic run_sweep();
    int pix_idx = 0, out_idx = 0, cyc = 0;
    bit done = 1'b0;
    logic [35:0] ew;
    longint got, want;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 10; c++) s_img[r][c] = int'($urandom_range(0, 600)) - 300;
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          s_k[ch][i][j] = int'($urandom_range(0, 80)) - 40;
          @(negedge clk);
          s_kernel_we   = 1'b1;
          s_kernel_ch   = 2'(ch);
          s_kernel_row  = 2'(i);
          s_kernel_col  = 2'(j);
          s_kernel_data = 12'(s_k[ch][i][j]);
        end
    @(negedge clk);
    s_kernel_we = 1'b0;
    s_start     = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      s_fm_ready  = 1'($urandom_range(0, 1));
      s_pix_valid = (pix_idx < 70);
      s_pix_data  = (pix_idx < 70) ? 12'(s_img[pix_idx / 10][pix_idx % 10]) : 12'd0;
      #1;
      if (s_frame_done) done = 1'b1;
      if (s_fm_valid && s_fm_ready) begin
        got = longint'({s_fm_row, s_fm_col, s_fm_data});
        if (out_idx < 40) begin
          for (int ch = 0; ch < 3; ch++) ew[ch*12 +: 12] = 12'(s_model(out_idx / 8, out_idx % 8, ch));
          want = longint'({3'(out_idx / 8), 3'(out_idx % 8), ew});
        end else begin
          want = -1;
        end
        chk("sweep_out", got, want);
        out_idx++;
      end
      if (s_pix_valid && s_pix_ready) pix_idx++;
    end
    s_pix_valid = 1'b0;
    chk("sweep_frame_done_seen", longint'(done), 1);
    chk("sweep_nout", out_idx, 40);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    kernel_we = 0; kernel_ch = '0; kernel_row = '0; kernel_col = '0; kernel_data = '0;
    start = 0; pix_valid = 0; pix_data = '0; fm_ready = 1'b1;
    s_kernel_we = 0; s_kernel_ch = '0; s_kernel_row = '0; s_kernel_col = '0;
    s_kernel_data = '0; s_start = 0; s_pix_valid = 0; s_pix_data = '0; s_fm_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_pix_ready", longint'(pix_ready), 0);
    chk("reset_fm_valid", longint'(fm_valid), 0);
    chk("reset_frame_done", longint'(frame_done), 0);
    chk("reset_fm_word", longint'({fm_row, fm_col, fm_data}), 0);
    chk("reset_sweep_busy", longint'(s_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    load_kernels(T_IDENT);
    run_frame("ident", T_IDENT, 100, 1'b0, -1);
    run_frame("ident_bp", T_IDENT, 30, 1'b0, -1);
    run_frame("ctrl", T_IDENT, 100, 1'b1, -1);
    load_kernels(T_CORNER);
    run_frame("corner", T_CORNER, 50, 1'b0, -1);
    load_kernels(T_BOX);
    run_frame("box", T_BOX, 100, 1'b0, -1);
    load_kernels(T_SATP);
    run_frame("satp", T_SATP, 100, 1'b0, -1);
    run_frame("satn", T_SATN, 100, 1'b0, -1);

    run_frame("abort", T_SATN, 100, 1'b0, 500);
    pix_valid = 1'b0; start = 1'b0; kernel_we = 1'b0; fm_ready = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    n_quiet = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (frame_done || fm_valid || busy) n_quiet++;
    end
    chk("abort_quiet", n_quiet, 0);
    run_frame("zero_kern", T_ZERO, 100, 1'b0, -1);
    load_kernels(T_IDENT);
    run_frame("post_rst", T_IDENT, 70, 1'b0, -1);

    run_sweep();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
